// File: rtl/if_id_queue.sv
// Decoupling FIFO between instruction fetch and decode. Provides fetch back-pressure,
// branch/jump flush, and halt ordering (no fetch accepted after a halt word).
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] if_inst,
  input  logic [WIDTH-1:0] if_pc4,
  input  logic             if_halted,
  output logic             if_ready,
  input  logic             flush,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_inst,
  output logic [WIDTH-1:0] id_pc4,
  output logic             id_halted,
  output logic             halt_issued,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] pc4_mem  [DEPTH];
  logic [DEPTH-1:0] halt_mem;

  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             halt_pending_reg, halt_pending_next;
  logic             halt_issued_reg, halt_issued_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic push;
  logic pop;
  logic stall;

  // if_ready depends only on registered state, so a pop never frees a slot in the same cycle
  assign if_ready = (count_reg < DEPTH_C) && !halt_pending_reg && !halt_issued_reg;
  assign id_valid = (count_reg != '0);

  assign push  = if_valid && if_ready && !flush;
  assign pop   = id_valid && id_ready && !flush;
  assign stall = id_valid && !id_ready && !flush;

  assign id_inst     = id_valid ? inst_mem[rd_ptr_reg] : '0;
  assign id_pc4      = id_valid ? pc4_mem[rd_ptr_reg]  : '0;
  assign id_halted   = id_valid ? halt_mem[rd_ptr_reg] : 1'b0;
  assign halt_issued = halt_issued_reg;
  assign stall_cnt   = stall_cnt_reg;

  // Payload storage needs no reset: count_reg alone qualifies the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_reg] <= if_inst;
      pc4_mem[wr_ptr_reg]  <= if_pc4;
      halt_mem[wr_ptr_reg] <= if_halted;
    end
  end

  always_comb begin
    rd_ptr_next       = rd_ptr_reg;
    wr_ptr_next       = wr_ptr_reg;
    count_next        = count_reg;
    halt_pending_next = halt_pending_reg;
    halt_issued_next  = halt_issued_reg;
    stall_cnt_next    = stall_cnt_reg;

    if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    if (flush) begin
      rd_ptr_next       = '0;
      wr_ptr_next       = '0;
      count_next        = '0;
      halt_pending_next = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
        if (if_halted) begin
          halt_pending_next = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
        // Only one halt can be queued, since pushes stop once it is accepted
        if (id_halted) begin
          halt_pending_next = 1'b0;
          halt_issued_next  = 1'b1;
        end
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      halt_pending_reg <= 1'b0;
      halt_issued_reg  <= 1'b0;
      stall_cnt_reg    <= '0;
    end else begin
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      count_reg        <= count_next;
      halt_pending_reg <= halt_pending_next;
      halt_issued_reg  <= halt_issued_next;
      stall_cnt_reg    <= stall_cnt_next;
    end
  end

endmodule
